mn_index_receiver: RTL and testbench

MN_INDEX_RECEIVER -- requirements
Module: mn_index_receiver

---
 rtl/mn_rx_pkg.sv | 11 +
 rtl/mn_rx_fifo.sv | 58 +++++
 rtl/mn_index_receiver.sv | 144 ++++++++++++++
 tb/tb_mn_index_receiver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mn_rx_pkg.sv
// Shared FSM state type and default sizing for the M/N index receiver.
package mn_rx_pkg;
   localparam int DefWidth     = 8;
   localparam int DefFifoDepth = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/mn_rx_fifo.sv
// Address FIFO: power-of-two depth, occupancy counter, a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mn_rx_fifo #(
   parameter int DataWidth = 16,
   parameter int Depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [DataWidth-1:0] data_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 full_o,
   output logic                 empty_o
);
   localparam int PtrW = $clog2(Depth);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]        cnt_q, cnt_d;
   logic                 do_push, do_pop;

   assign full_o  = cnt_q == (PtrW+1)'(Depth);
   assign empty_o = cnt_q == '0;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: contents are only observable while non-empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/mn_index_receiver.sv
// Receives (M,N) index beats, converts them to linear addresses and buffers them.
// Define MN_RX_ERR_CHECK_EN to enable the expected-index order checker (seq_err_o).
module mn_index_receiver
   import mn_rx_pkg::*;
#(
   parameter int Width     = DefWidth,
   parameter int FifoDepth = DefFifoDepth
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [Width-1:0]   M_size_i,
   input  logic [Width-1:0]   N_size_i,
   input  logic               in_valid_i,
   input  logic [Width-1:0]   in_M_i,
   input  logic [Width-1:0]   in_N_i,
   input  logic               in_last_i,
   output logic               in_ready_o,
   output logic [2*Width-1:0] addr_o,
   output logic               addr_valid_o,
   input  logic               addr_ready_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               ovf_o,
   output logic               seq_err_o
);
   localparam int AW = 2*Width;

   state_e           state_q, state_d;
   logic [Width-1:0] n_size_q, n_size_d;
   logic             done_q, done_d, ovf_q, ovf_d;
   logic             beat, pop, full, empty, start_ok;
   logic [AW-1:0]    beat_addr, head;

   assign start_ok  = state_q == IDLE && start_i && M_size_i != '0 && N_size_i != '0;
   assign beat      = state_q == RUN && in_valid_i;
   assign pop       = addr_valid_o && addr_ready_i;
   assign beat_addr = AW'(in_M_i) * AW'(n_size_q) + AW'(in_N_i);

   mn_rx_fifo #(.DataWidth(AW), .Depth(FifoDepth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (beat),
      .pop_i   (pop),
      .data_i  (beat_addr),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d  = state_q;
      n_size_d = n_size_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: if (start_ok) begin
            state_d  = RUN;
            n_size_d = N_size_i;
            ovf_d    = 1'b0;
         end else if (start_i) begin
            done_d = 1'b1;
         end
         RUN: if (in_valid_i) begin
            if (full && !pop) ovf_d = 1'b1;
            if (in_last_i) state_d = DRAIN;
         end
         DRAIN: if (empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         n_size_q <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_size_q <= n_size_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef MN_RX_ERR_CHECK_EN
   logic [Width-1:0] m_size_q, m_size_d, exp_m_q, exp_m_d, exp_n_q, exp_n_d;
   logic             seq_err_q, seq_err_d, at_final, bad_beat;

   assign at_final = exp_m_q == m_size_q - Width'(1) && exp_n_q == n_size_q - Width'(1);
   // in_last_i must coincide exactly with the final expected index.
   assign bad_beat = in_M_i != exp_m_q || in_N_i != exp_n_q || in_last_i != at_final;

   always_comb begin
      m_size_d  = m_size_q;
      exp_m_d   = exp_m_q;
      exp_n_d   = exp_n_q;
      seq_err_d = seq_err_q;
      if (start_ok) begin
         m_size_d  = M_size_i;
         exp_m_d   = '0;
         exp_n_d   = '0;
         seq_err_d = 1'b0;
      end else if (beat) begin
         if (bad_beat) seq_err_d = 1'b1;
         if (!at_final) begin
            if (exp_n_q == n_size_q - Width'(1)) begin
               exp_n_d = '0;
               exp_m_d = exp_m_q + Width'(1);
            end else begin
               exp_n_d = exp_n_q + Width'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_size_q  <= '0;
         exp_m_q   <= '0;
         exp_n_q   <= '0;
         seq_err_q <= 1'b0;
      end else begin
         m_size_q  <= m_size_d;
         exp_m_q   <= exp_m_d;
         exp_n_q   <= exp_n_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign seq_err_o = seq_err_q;
`else
   assign seq_err_o = 1'b0;
`endif

   assign addr_valid_o = !empty;
   assign addr_o       = empty ? '0 : head;
   assign in_ready_o   = !full;
   assign busy_o       = state_q != IDLE;
   // Drain completion is flagged in the cycle the FIFO is seen empty.
   assign done_o       = done_q || (state_q == DRAIN && empty);
   assign ovf_o        = ovf_q;
endmodule

// File: tb/tb_mn_index_receiver.sv
// Randomised bench for mn_index_receiver against a queue-based reference model.
module tb_mn_index_receiver;
   localparam int W = 8;
   localparam int D = 4;
`ifdef MN_RX_ERR_CHECK_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic           clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
   logic           in_valid_i = 1'b0, in_last_i = 1'b0, addr_ready_i = 1'b0;
   logic [W-1:0]   M_size_i = '0, N_size_i = '0, in_M_i = '0, in_N_i = '0;
   logic           in_ready_o, addr_valid_o, busy_o, done_o, ovf_o, seq_err_o;
   logic [2*W-1:0] addr_o;

   int n_chk = 0, n_pass = 0;

   // Reference model: FIFO contents as a queue, phase 0=idle 1=run 2=drain,
   // expected index as a linear beat count k over an mm x mn grid.
   int unsigned mq[$];
   int unsigned popped[$];
   int          st = 0, mm = 0, mn = 0, k = 0;
   bit          m_ovf = 0, m_serr = 0, m_done_pend = 0;

   always #5 clk_i = ~clk_i;

   mn_index_receiver dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .M_size_i(M_size_i), .N_size_i(N_size_i),
      .in_valid_i(in_valid_i), .in_M_i(in_M_i), .in_N_i(in_N_i), .in_last_i(in_last_i),
      .in_ready_o(in_ready_o), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
      .addr_ready_i(addr_ready_i), .busy_o(busy_o), .done_o(done_o),
      .ovf_o(ovf_o), .seq_err_o(seq_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic m_reset();
      mq.delete();
      st = 0; m_ovf = 0; m_serr = 0; m_done_pend = 0;
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, advance the model.
   task automatic cyc(input bit v, input int m, input int n, input bit last,
                      input bit rdy, input bit go, input int msz, input int nsz);
      bit pop, do_push, fin;
      int unsigned a;
      in_valid_i = v; in_M_i = W'(m); in_N_i = W'(n); in_last_i = last;
      addr_ready_i = rdy; start_i = go; M_size_i = W'(msz); N_size_i = W'(nsz);
      @(negedge clk_i);
      chk("addr_valid", addr_valid_o, mq.size() != 0);
      chk("addr", addr_o, mq.size() != 0 ? mq[0] : 0);
      chk("in_ready", in_ready_o, mq.size() < D);
      chk("busy", busy_o, st != 0);
      chk("done", done_o, m_done_pend || (st == 2 && mq.size() == 0));
      chk("ovf", ovf_o, m_ovf);
      chk("seq_err", seq_err_o, m_serr);
      pop = mq.size() != 0 && rdy;
      do_push = 0;
      a = 0;
      m_done_pend = 0;
      if (st == 0) begin
         if (go) begin
            if (msz == 0 || nsz == 0) m_done_pend = 1;
            else begin
               st = 1; mm = msz; mn = nsz; k = 0; m_ovf = 0; m_serr = 0;
            end
         end
      end else if (st == 1) begin
         if (v) begin
            a = m * mn + n;
            if (mq.size() < D || pop) do_push = 1;
            else m_ovf = 1;
            fin = (k == mm * mn - 1);
            if (m != k / mn || n != k % mn || last != fin) m_serr = m_serr | ErrEn;
            if (!fin) k++;
            if (last) st = 2;
         end
      end else if (mq.size() == 0) begin
         st = 0;
      end
      if (pop) popped.push_back(mq.pop_front());
      if (do_push) mq.push_back(a);
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input int m, input int n, input bit last, input bit rdy);
      cyc(1'b1, m, n, last, rdy, 1'b0, 0, 0);
   endtask

   task automatic idle(input bit rdy);
      cyc(1'b0, 0, 0, 1'b0, rdy, 1'b0, 0, 0);
   endtask

   task automatic go(input int msz, input int nsz, input bit rdy);
      cyc(1'b0, 0, 0, 1'b0, rdy, 1'b1, msz, nsz);
   endtask

   // Run until the model is idle (bounded), with random or fixed ready.
   task automatic drain(input bit rand_rdy);
      for (int i = 0; i < 200 && st != 0; i++)
         idle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      idle(1'b1);
      chk("drain_busy", busy_o, 0);
   endtask

   initial begin
      #12;
      chk("rst_addr_valid", addr_valid_o, 0);
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_flags", {ovf_o, seq_err_o}, 0);
      chk("rst_addr", addr_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      idle(1'b1);

      // 2x3 in order, ready held high
      popped.delete();
      go(2, 3, 1);
      for (int i = 0; i < 6; i++) beat(i / 3, i % 3, i == 5, 1'b1);
      drain(1'b0);
      chk("s1_count", popped.size(), 6);
      foreach (popped[i]) chk("s1_addr", popped[i], i);
      chk("s1_flags", {ovf_o, seq_err_o}, 0);

      // 1x1 single beat
      popped.delete();
      go(1, 1, 1);
      beat(0, 0, 1'b1, 1'b1);
      drain(1'b0);
      chk("s2_addr", popped.size() == 1 ? popped[0] : 32'hffff, 0);
      chk("s2_seq_err", seq_err_o, 0);

      // 2x2 with output stalled: fifth beat overflows
      popped.delete();
      go(2, 2, 0);
      beat(0, 0, 1'b0, 1'b0);
      beat(0, 1, 1'b0, 1'b0);
      beat(1, 0, 1'b0, 1'b0);
      beat(1, 1, 1'b0, 1'b0);
      beat(1, 1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      chk("s3_ovf", ovf_o, 1);
      chk("s3_busy_stalled", busy_o, 1);
      chk("s3_full", in_ready_o, 0);
      drain(1'b0);
      chk("s3_count", popped.size(), 4);
      foreach (popped[i]) chk("s3_addr", popped[i], i);

      // 3x3 with an out-of-order second beat
      popped.delete();
      go(3, 3, 1);
      beat(0, 0, 1'b0, 1'b1);
      beat(0, 2, 1'b0, 1'b1);
      chk("s4_seq_err", seq_err_o, ErrEn);
      for (int i = 2; i < 9; i++) beat(i / 3, i % 3, i == 8, 1'b1);
      drain(1'b0);
      chk("s4_second_addr", popped.size() > 1 ? popped[1] : 32'hffff, 2);

      // zero-size start
      go(0, 3, 1);
      chk("s5_busy", busy_o, 0);
      idle(1'b1);
      idle(1'b1);

      // reset mid-RUN
      go(4, 4, 0);
      for (int i = 0; i < 3; i++) beat(0, i, 1'b0, 1'b0);
      rst_ni = 1'b0;
      #1;
      chk("s6_addr_valid", addr_valid_o, 0);
      chk("s6_busy", busy_o, 0);
      chk("s6_done", done_o, 0);
      chk("s6_in_ready", in_ready_o, 1);
      m_reset();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b1);

      // randomised runs with gaps, stalls, ignored starts and stray beats
      for (int r = 0; r < 25; r++) begin
         int msz, nsz;
         msz = $urandom_range(1, 4);
         nsz = $urandom_range(1, 4);
         if ($urandom_range(0, 3) == 0)
            cyc(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1, 1'b0, 0, 0);
         go(msz, nsz, 1'($urandom_range(0, 1)));
         for (int i = 0; i < msz * nsz; i++) begin
            int bm, bn;
            while ($urandom_range(0, 2) == 0)
               cyc(1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
            bm = i / nsz;
            bn = i % nsz;
            if ($urandom_range(0, 9) == 0) bn = (bn + 1) % 4;
            beat(bm, bn, i == msz * nsz - 1, 1'($urandom_range(0, 1)));
         end
         drain(1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
